// File: rtl/jtag_user_cmd_ctrl.sv
// Purpose: decodes JTAG user-register commands into single register-bus transactions and event polls, formats the response word.
// Latency: NOP/POLL respond in the cycle after update; WRITE/READ respond the cycle after bus_ack or timeout (minimum 2 cycles).
// Backpressure: none towards the host; an update arriving while a bus transaction is in flight is dropped and flagged as overrun.
module jtag_user_cmd_ctrl #(
    parameter int N_REQ   = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64,
    localparam int CMD_W  = 6 + ADDR_W + DATA_W,
    localparam int RSP_W  = 12 + DATA_W
) (
    input  logic                    TCK,
    input  logic                    reset_n,
    input  logic                    update,
    input  logic [CMD_W-1:0]        cmd_word,
    output logic [RSP_W-1:0]        rsp_word,
    output logic                    bus_req,
    output logic                    bus_we,
    output logic [ADDR_W-1:0]       bus_addr,
    output logic [DATA_W-1:0]       bus_wdata,
    input  logic                    bus_ack,
    input  logic [DATA_W-1:0]       bus_rdata,
    input  logic [N_REQ-1:0]        evt_req,
    input  logic [N_REQ*DATA_W-1:0] evt_data,
    output logic [N_REQ-1:0]        evt_ack
);

    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUS  = 1'b1
    } state_t;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_POLL  = 2'b11;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [3:0]          pend_tag_q, pend_tag_d;
    logic                bus_we_q, bus_we_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
    logic [3:0]          tag_q, tag_d;
    logic                err_to_q, err_to_d;
    logic                err_ov_q, err_ov_d;
    logic                evt_valid_q, evt_valid_d;
    logic [3:0]          src_q, src_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [N_REQ-1:0]    evt_ack_q, evt_ack_d;
    logic [3:0]          last_q, last_d;

    logic [1:0]          cmd_op;
    logic [3:0]          cmd_tag;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [DATA_W-1:0]   cmd_data;

    logic                win_found;
    logic [3:0]          win_idx;
    logic [DATA_W-1:0]   win_data;
    logic [N_REQ-1:0]    win_onehot;

    assign cmd_op   = cmd_word[CMD_W-1 -: 2];
    assign cmd_tag  = cmd_word[CMD_W-3 -: 4];
    assign cmd_addr = cmd_word[DATA_W +: ADDR_W];
    assign cmd_data = cmd_word[DATA_W-1:0];

    // Round-robin pick: first requester above last grant, else first at or below it (wrap).
    always_comb begin
        win_found  = 1'b0;
        win_idx    = '0;
        win_data   = '0;
        win_onehot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!win_found && evt_req[i] && (4'(i) > last_q)) begin
                win_found = 1'b1;
                win_idx   = 4'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!win_found && evt_req[i] && (4'(i) <= last_q)) begin
                win_found = 1'b1;
                win_idx   = 4'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (win_found && (win_idx == 4'(i))) begin
                win_data      = evt_data[i*DATA_W +: DATA_W];
                win_onehot[i] = 1'b1;
            end
        end
    end

    // Command decode, bus transaction tracking with timeout, and response field updates.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_tag_d  = pend_tag_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        tag_d       = tag_q;
        err_to_d    = err_to_q;
        err_ov_d    = err_ov_q;
        evt_valid_d = evt_valid_q;
        src_d       = src_q;
        rdata_d     = rdata_q;
        evt_ack_d   = '0;
        last_d      = last_q;

        case (state_q)
            ST_IDLE: begin
                if (update) begin
                    err_to_d = 1'b0;
                    err_ov_d = 1'b0;
                    case (cmd_op)
                        OP_NOP: begin
                            tag_d       = cmd_tag;
                            evt_valid_d = 1'b0;
                        end
                        OP_WRITE, OP_READ: begin
                            state_d     = ST_BUS;
                            cnt_d       = '0;
                            pend_tag_d  = cmd_tag;
                            bus_we_d    = (cmd_op == OP_WRITE);
                            bus_addr_d  = cmd_addr;
                            bus_wdata_d = cmd_data;
                        end
                        default: begin
                            tag_d = cmd_tag;
                            if (win_found) begin
                                evt_ack_d   = win_onehot;
                                src_d       = win_idx;
                                rdata_d     = win_data;
                                evt_valid_d = 1'b1;
                                last_d      = win_idx;
                            end else begin
                                src_d       = '0;
                                rdata_d     = '0;
                                evt_valid_d = 1'b0;
                            end
                        end
                    endcase
                end
            end
            default: begin
                // The host must wait for busy to drop; anything sooner is lost.
                if (update) begin
                    err_ov_d = 1'b1;
                end
                if (bus_ack) begin
                    state_d     = ST_IDLE;
                    tag_d       = pend_tag_q;
                    evt_valid_d = 1'b0;
                    rdata_d     = bus_we_q ? bus_wdata_q : bus_rdata;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d     = ST_IDLE;
                    tag_d       = pend_tag_q;
                    evt_valid_d = 1'b0;
                    rdata_d     = '1;
                    err_to_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge TCK) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            pend_tag_q  <= '0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            tag_q       <= '0;
            err_to_q    <= 1'b0;
            err_ov_q    <= 1'b0;
            evt_valid_q <= 1'b0;
            src_q       <= '0;
            rdata_q     <= '0;
            evt_ack_q   <= '0;
            last_q      <= 4'(N_REQ - 1);
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_tag_q  <= pend_tag_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            tag_q       <= tag_d;
            err_to_q    <= err_to_d;
            err_ov_q    <= err_ov_d;
            evt_valid_q <= evt_valid_d;
            src_q       <= src_d;
            rdata_q     <= rdata_d;
            evt_ack_q   <= evt_ack_d;
            last_q      <= last_d;
        end
    end

    assign bus_req   = (state_q == ST_BUS);
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign evt_ack   = evt_ack_q;
    assign rsp_word  = {tag_q, (state_q == ST_BUS), err_to_q, err_ov_q, evt_valid_q, src_q, rdata_q};

endmodule

// File: tb/tb_jtag_user_cmd_ctrl.sv
// Purpose: directed bench for jtag_user_cmd_ctrl with a transaction-level reference model and per-cycle compare.
// Latency: model updates on each rising TCK edge; outputs are compared on the falling edge.
// Backpressure: bus_ack timing and overlapping updates are driven from the stimulus tasks.
module tb_jtag_user_cmd_ctrl;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int TO = 64;
    localparam int CW = 6 + AW + DW;
    localparam int RW = 12 + DW;

    logic          TCK = 1'b0;
    logic          reset_n;
    logic          update;
    logic [CW-1:0] cmd_word;
    logic [RW-1:0] rsp_word;
    logic          bus_req;
    logic          bus_we;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic          bus_ack;
    logic [DW-1:0] bus_rdata;
    logic [N-1:0]  evt_req;
    logic [N*DW-1:0] evt_data;
    logic [N-1:0]  evt_ack;

    int checks   = 0;
    int failures = 0;
    logic cmp_en = 1'b0;

    jtag_user_cmd_ctrl #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .TCK(TCK), .reset_n(reset_n), .update(update), .cmd_word(cmd_word),
        .rsp_word(rsp_word), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .evt_req(evt_req), .evt_data(evt_data), .evt_ack(evt_ack)
    );

    always #5 TCK = ~TCK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic          m_busy, m_to, m_ov, m_ev, m_we;
    logic [3:0]    m_tag, m_src, m_ptag;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;
    logic [N-1:0]  m_ack;
    int            m_age, m_last;

    function automatic int pick(input logic [N-1:0] req, input int last);
        for (int k = 1; k <= N; k++) begin
            if (req[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [DW-1:0] evt_pattern(input int idx);
        return 32'hE000_0000 | 32'(idx);
    endfunction

    always @(posedge TCK) begin
        int w;
        logic done, tout;
        m_ack = '0;
        done  = 1'b0;
        tout  = 1'b0;
        if (!reset_n) begin
            m_busy = 0; m_to = 0; m_ov = 0; m_ev = 0; m_we = 0;
            m_tag = 0; m_src = 0; m_ptag = 0; m_addr = 0; m_wdata = 0; m_rdata = 0;
            m_age = 0; m_last = N - 1;
        end else if (m_busy) begin
            if (update) m_ov = 1'b1;
            if (bus_ack) done = 1'b1;
            else if (m_age + 1 == TO) begin done = 1'b1; tout = 1'b1; end
            else m_age++;
            if (done) begin
                m_busy  = 1'b0;
                m_tag   = m_ptag;
                m_ev    = 1'b0;
                m_to    = tout;
                m_rdata = tout ? '1 : (m_we ? m_wdata : bus_rdata);
            end
        end else if (update) begin
            m_to = 1'b0;
            m_ov = 1'b0;
            case (cmd_word[CW-1 -: 2])
                2'b00: begin m_tag = cmd_word[CW-3 -: 4]; m_ev = 1'b0; end
                2'b01, 2'b10: begin
                    m_busy  = 1'b1;
                    m_age   = 0;
                    m_ptag  = cmd_word[CW-3 -: 4];
                    m_we    = (cmd_word[CW-1 -: 2] == 2'b01);
                    m_addr  = cmd_word[DW +: AW];
                    m_wdata = cmd_word[DW-1:0];
                end
                default: begin
                    m_tag = cmd_word[CW-3 -: 4];
                    w = pick(evt_req, m_last);
                    if (w >= 0) begin
                        m_ack   = N'(1) << w;
                        m_src   = 4'(w);
                        m_rdata = evt_pattern(w);
                        m_ev    = 1'b1;
                        m_last  = w;
                    end else begin
                        m_ev = 1'b0; m_src = 0; m_rdata = 0;
                    end
                end
            endcase
        end
    end

    // Per-cycle compare of every DUT output against the model.
    always @(negedge TCK) begin
        if (cmp_en) begin
            chk("rsp_word", 64'(rsp_word), 64'({m_tag, m_busy, m_to, m_ov, m_ev, m_src, m_rdata}));
            chk("bus_req", 64'(bus_req), 64'(m_busy));
            chk("evt_ack", 64'(evt_ack), 64'(m_ack));
            if (m_busy) begin
                chk("bus_we", 64'(bus_we), 64'(m_we));
                chk("bus_addr", 64'(bus_addr), 64'(m_addr));
                chk("bus_wdata", 64'(bus_wdata), 64'(m_wdata));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic [1:0] op, input logic [3:0] tag,
                         input logic [AW-1:0] addr, input logic [DW-1:0] data);
        cmd_word = {op, tag, addr, data};
        update   = 1'b1;
        @(negedge TCK);
        update   = 1'b0;
    endtask

    // Counts bus_req cycles; acks in cycle ack_at (0 = never), injects an update in cycle ovr_at.
    task automatic run_bus(input int ack_at, input int ovr_at, input logic [DW-1:0] rd, output int nreq);
        nreq = 0;
        for (int g = 0; g < 200 && bus_req; g++) begin
            nreq++;
            bus_ack   = (nreq == ack_at);
            bus_rdata = rd;
            if (nreq == ovr_at) begin
                cmd_word = {2'b10, 4'hF, 8'h77, 32'h0};
                update   = 1'b1;
            end else begin
                update = 1'b0;
            end
            @(negedge TCK);
        end
        bus_ack = 1'b0;
        update  = 1'b0;
    endtask

    logic [3:0] poll_src [4] = '{4'd0, 4'd1, 4'd3, 4'd0};

    initial begin
        int n;
        reset_n = 1'b0; update = 1'b0; cmd_word = '0; bus_ack = 1'b0; bus_rdata = '0; evt_req = '0;
        for (int i = 0; i < N; i++) evt_data[i*DW +: DW] = evt_pattern(i);
        @(negedge TCK);
        @(negedge TCK);
        cmp_en = 1'b1;
        chk("reset_rsp", 64'(rsp_word), 64'd0);
        chk("reset_req", 64'(bus_req), 64'd0);
        chk("reset_ack", 64'(evt_ack), 64'd0);
        reset_n = 1'b1;

        // Stray ack while idle must be ignored.
        bus_ack = 1'b1;
        @(negedge TCK);
        bus_ack = 1'b0;
        chk("stray_ack", 64'(bus_req), 64'd0);

        // WRITE, ack in the third request cycle.
        issue(2'b01, 4'd3, 8'h10, 32'hA5A5A5A5);
        chk("wr_we", 64'(bus_we), 64'd1);
        chk("wr_busy", 64'(rsp_word[RW-5]), 64'd1);
        run_bus(3, 0, 32'h0, n);
        chk("wr_len", 64'(n), 64'd3);
        chk("wr_rsp", 64'(rsp_word), 64'({4'd3, 4'b0000, 4'd0, 32'hA5A5A5A5}));

        // READ, ack in the first request cycle: two-cycle latency.
        issue(2'b10, 4'd5, 8'h20, 32'h0);
        run_bus(1, 0, 32'h12345678, n);
        chk("rd_len", 64'(n), 64'd1);
        chk("rd_rsp", 64'(rsp_word), 64'({4'd5, 4'b0000, 4'd0, 32'h12345678}));

        // READ with no ack: timeout after exactly TO request cycles.
        issue(2'b10, 4'd6, 8'h21, 32'h0);
        run_bus(0, 0, 32'hDEAD0000, n);
        chk("to_len", 64'(n), 64'(TO));
        chk("to_rsp", 64'(rsp_word), 64'({4'd6, 4'b0100, 4'd0, 32'hFFFFFFFF}));

        // NOP clears the timeout flag and latches its tag.
        issue(2'b00, 4'd7, 8'h0, 32'h0);
        chk("nop_hdr", 64'(rsp_word[RW-1 -: 8]), 64'({4'd7, 4'b0000}));

        // Ack on the final allowed cycle wins over timeout.
        issue(2'b10, 4'd8, 8'h22, 32'h0);
        run_bus(TO, 0, 32'hCAFEF00D, n);
        chk("last_len", 64'(n), 64'(TO));
        chk("last_rsp", 64'(rsp_word), 64'({4'd8, 4'b0000, 4'd0, 32'hCAFEF00D}));

        // Update during BUS is dropped and flagged.
        issue(2'b01, 4'd9, 8'h30, 32'h11111111);
        run_bus(4, 2, 32'h0, n);
        chk("ovr_len", 64'(n), 64'd4);
        chk("ovr_rsp", 64'(rsp_word), 64'({4'd9, 4'b0010, 4'd0, 32'h11111111}));
        for (int i = 0; i < 3; i++) begin
            @(negedge TCK);
            chk("ovr_nobus", 64'(bus_req), 64'd0);
        end

        // Update in the completion cycle is still an overrun.
        issue(2'b01, 4'd10, 8'h31, 32'h22222222);
        run_bus(2, 2, 32'h0, n);
        chk("ovr2_len", 64'(n), 64'd2);
        chk("ovr2_rsp", 64'(rsp_word), 64'({4'd10, 4'b0010, 4'd0, 32'h22222222}));
        @(negedge TCK);
        chk("ovr2_nobus", 64'(bus_req), 64'd0);

        // Round-robin polls over sources 0,1,3.
        evt_req = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            issue(2'b11, 4'(i + 1), 8'h0, 32'h0);
            chk("poll_ack", 64'(evt_ack), 64'(4'b0001 << poll_src[i]));
            chk("poll_rsp", 64'(rsp_word),
                64'({4'(i + 1), 4'b0001, poll_src[i], 32'hE0000000 | 32'(poll_src[i])}));
        end

        // No requester pending.
        evt_req = 4'b0000;
        issue(2'b11, 4'd5, 8'h0, 32'h0);
        chk("poll_none_rsp", 64'(rsp_word), 64'({4'd5, 4'b0000, 4'd0, 32'h0}));
        chk("poll_none_ack", 64'(evt_ack), 64'd0);

        // Only source 0 left: search from 1 wraps back to 0.
        evt_req = 4'b0001;
        issue(2'b11, 4'd6, 8'h0, 32'h0);
        chk("poll_wrap_rsp", 64'(rsp_word), 64'({4'd6, 4'b0001, 4'd0, 32'hE0000000}));
        chk("poll_wrap_ack", 64'(evt_ack), 64'd1);

        // NOP clears evt_valid.
        issue(2'b00, 4'd8, 8'h0, 32'h0);
        chk("nop_evt", 64'(rsp_word[RW-8]), 64'd0);

        // Reset mid-transaction.
        issue(2'b10, 4'd9, 8'h40, 32'h0);
        @(negedge TCK);
        @(negedge TCK);
        reset_n = 1'b0;
        @(negedge TCK);
        chk("rst_req", 64'(bus_req), 64'd0);
        chk("rst_rsp", 64'(rsp_word), 64'd0);
        reset_n = 1'b1;
        evt_req = 4'b1111;
        issue(2'b11, 4'd3, 8'h0, 32'h0);
        chk("rst_poll_rsp", 64'(rsp_word), 64'({4'd3, 4'b0001, 4'd0, 32'hE0000000}));
        chk("rst_poll_ack", 64'(evt_ack), 64'd1);

        repeat (3) @(negedge TCK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jtag_user_cmd_ctrl.md
# jtag_user_cmd_ctrl

Command sequencer between the JTAG user-register shifter and the on-chip fabric, running entirely in the TCK domain. Decodes each host command word shifted in over JTAG and issues single register-bus read/write transactions with an ack timeout. Round-robin arbitrates N event sources for the single JTAG readback word. Formats the parallel response word that the shifter loads and shifts out.

## Interface
- N_REQ, 4: number of event requesters (1..16)
- ADDR_W, 8: bus address width
- DATA_W, 32: bus/event data width
- TIMEOUT, 64: max bus_req cycles before abort (>=2)
- CMD_W, 6+ADDR_W+DATA_W: derived. Command layout, MSB first: opcode[1:0], tag[3:0], addr[ADDR_W-1:0], data[DATA_W-1:0]
- RSP_W, 12+DATA_W: derived. Response layout, MSB first: tag[3:0], busy, err_timeout, err_overrun, evt_valid, src[3:0], rdata[DATA_W-1:0]

Ports:
- TCK  in  1  sole clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- update  in  1  one-cycle pulse: cmd_word holds a new command
- cmd_word  in  CMD_W  parallel command from the shifter
- rsp_word  out  RSP_W  parallel response to the shifter, registered
- bus_req  out  1  transaction request, held until ack or timeout
- bus_we  out  1  1 = write, 0 = read; stable while bus_req
- bus_addr  out  ADDR_W  stable while bus_req
- bus_wdata  out  DATA_W  stable while bus_req
- bus_ack  in  1  completion, sampled only while bus_req = 1
- bus_rdata  in  DATA_W  read data, valid with bus_ack
- evt_req  in  N_REQ  per-source pending event, level
- evt_data  in  N_REQ*DATA_W  source i occupies bits [i*DATA_W +: DATA_W]
- evt_ack  out  N_REQ  one-hot, one-cycle pulse: event consumed

## Operation
- Opcodes:
  - 00 NOP: latch tag; clear err_timeout and err_overrun.
  - 01 WRITE: bus write.
  - 10 READ: bus read.
  - 11 POLL: event fetch.
- States:
  - IDLE. update with WRITE/READ -> BUS. NOP/POLL complete within IDLE.
  - BUS. bus_ack = 1 -> IDLE, or timeout -> IDLE.
- Accepting any command in IDLE clears err_timeout and err_overrun, except as set below.
- busy = (state == BUS).
- update while in BUS: command ignored; err_overrun set, sticky until the next accepted command.
- WRITE completion: rdata = wdata echo.
- READ completion: rdata = bus_rdata.
- Timeout: rdata = all ones; err_timeout = 1.
- rsp tag changes only when a command completes. It carries the completing command's tag.
- POLL arbitration:
  - Search starts at (last_grant+1) mod N_REQ and wraps; last_grant resets to N_REQ-1, so the first search starts at source 0.
  - Winner: evt_ack pulse; src = index; rdata = evt_data slice; evt_valid = 1; last_grant = index.
  - No evt_req: evt_valid = 0, src = 0, rdata = 0; last_grant unchanged.
- evt_valid is cleared by any non-POLL completion.
- Reset values: rsp_word all 0, bus_req 0, bus_we 0, bus_addr 0, bus_wdata 0, evt_ack 0, state IDLE.

## Timing
- WRITE/READ:
  - update at edge t -> bus_req = 1 and busy = 1 in cycle t+1.
  - bus_ack sampled high at edge k -> bus_req = 0, busy = 0, rsp_word updated in cycle k+1.
  - Minimum latency, update to response: 2 cycles.
- Timeout counter:
  - Clears on BUS entry and increments each BUS cycle.
  - If no ack by the TIMEOUT-th bus_req cycle, abort at that edge; bus_req is high exactly TIMEOUT cycles.
  - Ack on the final cycle wins: normal completion, no error.
- POLL and NOP: response, and evt_ack for POLL, in cycle t+1.
- update in the same cycle as completion in BUS is still an overrun: command dropped.
- Next command is accepted in the first IDLE cycle.
- bus_ack while bus_req = 0: ignored.
- evt_req dropping before POLL: the source is not granted.
- reset_n low mid-transaction: bus_req low after the next edge; no completion reported; counters and last_grant cleared.

## Test plan
- Reset, then WRITE tag=3 addr=0x10 data=0xA5A5A5A5, ack after 3 cycles:
  - bus_req high 3 cycles, we=1.
  - Then rsp tag=3, busy=0, rdata=0xA5A5A5A5, errs=0.
- READ tag=5 addr=0x20, ack same cycle as first req, bus_rdata=0x12345678:
  - 2-cycle latency; rsp rdata=0x12345678, tag=5.
- READ, no ack, TIMEOUT=64:
  - bus_req high exactly 64 cycles; rsp err_timeout=1, rdata=0xFFFFFFFF.
  - Following NOP clears err_timeout.
- Ack on the 64th cycle:
  - Normal completion, err_timeout=0.
- update issued while BUS:
  - Command dropped; err_overrun=1 on completion of the in-flight transaction.
  - Bus sees only one transaction.
- evt_req=4'b1011, four POLLs:
  - Grants src 0, 1, 3, 0, with matching evt_ack pulses and data.
  - With evt_req=0: evt_valid=0, src=0, rdata=0.
- Reset asserted mid-BUS:
  - bus_req=0 after the next edge; rsp_word=0.
  - Post-reset POLL with all evt_req set grants src 0.
